// File: rtl/alu_multicycle.sv
// alu_multicycle: 32-bit ALU behind a valid/ready handshake on each side.
// Logic, add/sub and compare operations finish in one cycle. Shifts move one
// bit position per cycle, so a shift by n keeps the block busy for n cycles.
//
// Ports
//   clk        clock; all state updates on the rising edge
//   reset      synchronous, active-high reset
//   in_valid   request present on Operation/SrcA/SrcB
//   in_ready   block can accept a request this cycle (high only in IDLE)
//   Operation  4-bit operation code
//   SrcA       first operand
//   SrcB       second operand; shifts use SrcB[4:0] as the shift amount
//   out_valid  ALUResult/Zero/Illegal hold a completed result (high only in DONE)
//   out_ready  consumer accepts the result this cycle
//   ALUResult  registered result
//   Zero       registered, 1 when ALUResult == 0
//   Illegal    registered, 1 when the accepted Operation is unencoded
module alu_multicycle (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  Operation,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] ALUResult,
    output logic        Zero,
    output logic        Illegal
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRL = 4'b0101;
    localparam logic [3:0] OP_SRA = 4'b0111;

    state_t      state;
    logic [3:0]  op_q;
    logic [31:0] work;
    logic [4:0]  cnt;

    logic [32:0] eval;
    logic [31:0] shift_next;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

    // One bit position of the serial shifter.
    function automatic logic [31:0] shift_one(input logic [3:0] op, input logic [31:0] v);
        logic [31:0] r;
        case (op)
            OP_SLL:  r = v << 1;
            OP_SRL:  r = v >> 1;
            default: r = {v[31], v[31:1]};
        endcase
        return r;
    endfunction

    // Single-cycle evaluation; returns {illegal, result}. Shift codes only
    // reach here with a zero shift amount, so they pass SrcA through.
    function automatic logic [32:0] alu_eval(input logic [3:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [31:0]        r;
        logic               ill;
        sa  = a;
        sb  = b;
        r   = '0;
        ill = 1'b0;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = a + b;
            4'b0011: r = a ^ b;
            4'b0110: r = a - b;
            4'b0100,
            4'b0101,
            4'b0111: r = a;
            4'b1000: r = {31'd0, a == b};
            4'b1001: r = {31'd0, sa >= sb};
            4'b1100: r = {31'd0, sa < sb};
            default: ill = 1'b1;
        endcase
        return {ill, r};
    endfunction

    always_comb begin
        eval       = alu_eval(Operation, SrcA, SrcB);
        shift_next = shift_one(op_q, work);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            ALUResult <= '0;
            Zero      <= 1'b1;
            Illegal   <= 1'b0;
            cnt       <= '0;
            op_q      <= '0;
            work      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q     <= Operation;
                        work     <= SrcA;
                        in_ready <= 1'b0;
                        if (is_shift(Operation) && (SrcB[4:0] != 5'd0)) begin
                            cnt   <= SrcB[4:0];
                            state <= SHIFT;
                        end else begin
                            ALUResult <= eval[31:0];
                            Zero      <= (eval[31:0] == 32'd0);
                            Illegal   <= eval[32];
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    work <= shift_next;
                    cnt  <= cnt - 5'd1;
                    // Last step: publish the shifted value directly.
                    if (cnt == 5'd1) begin
                        ALUResult <= shift_next;
                        Zero      <= (shift_next == 32'd0);
                        Illegal   <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: driver pushes expected results into a scoreboard
// queue at issue time, a monitor pops and compares when the DUT presents one.
module tb_alu_multicycle;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  Operation;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        Illegal;

    alu_multicycle dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .Operation(Operation), .SrcA(SrcA), .SrcB(SrcB),
        .out_valid(out_valid), .out_ready(out_ready),
        .ALUResult(ALUResult), .Zero(Zero), .Illegal(Illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        ill;
        int          acc;   // cycle number of the accepting edge
        int          off;   // edges after accept before out_valid is seen
    } exp_t;

    exp_t        scb[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          stall_req = 0;
    logic        have_cur = 1'b0;
    logic [31:0] hold_res = '0;
    logic        hold_zero = 1'b1;
    logic        hold_ill = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model from the operation table, using plain arithmetic.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ill, output int off);
        int sh;
        sh  = int'(b[4:0]);
        ill = 1'b0;
        off = 0;
        r   = '0;
        case (op)
            4'h0: r = a & b;
            4'h1: r = a | b;
            4'h2: r = a + b;
            4'h3: r = a ^ b;
            4'h4: begin r = a << sh; off = sh; end
            4'h5: begin r = a >> sh; off = sh; end
            4'h6: r = a - b;
            4'h7: begin r = $unsigned($signed(a) >>> sh); off = sh; end
            4'h8: r = (a == b) ? 32'd1 : 32'd0;
            4'h9: r = ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
            4'hC: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: ill = 1'b1;
        endcase
    endfunction

    // Issue one request; returns after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int stall);
        exp_t e;
        int   guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready) begin
            // Requests while busy must be ignored.
            in_valid  = $urandom_range(0, 1);
            Operation = 4'($urandom);
            SrcA      = $urandom;
            SrcB      = $urandom;
            guard++;
            if (guard > 200) begin
                bad++;
                total++;
                $display("FAIL in_ready_timeout: got 0 want 1 after %0d cycles", guard);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        in_valid  = 1'b1;
        Operation = op;
        SrcA      = a;
        SrcB      = b;
        model(op, a, b, e.res, e.ill, e.off);
        e.zero    = (e.res == 32'd0);
        e.acc     = cyc + 1;
        stall_req = stall;
        scb.push_back(e);
        @(negedge clk);
        in_valid  = 1'b0;
        Operation = 4'($urandom);
        SrcA      = $urandom;
        SrcB      = $urandom;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((scb.size() != 0) || have_cur || out_valid) begin
            @(negedge clk);
            guard++;
            if (guard > 2000) begin
                bad++;
                total++;
                $display("FAIL drain_timeout: got %0d pending want 0", scb.size());
                return;
            end
        end
        @(negedge clk);
    endtask

    // Monitor / scoreboard checker; also drives consumer backpressure.
    initial begin
        exp_t cur;
        logic expect_idle;
        expect_idle = 1'b0;
        out_ready   = 1'b0;
        cur         = '{res: '0, zero: 1'b1, ill: 1'b0, acc: 0, off: 0};
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (reset) begin
                have_cur    = 1'b0;
                expect_idle = 1'b0;
                continue;
            end
            if (expect_idle) begin
                check("release_to_idle", {30'd0, out_valid, in_ready}, 32'd1);
                expect_idle = 1'b0;
            end
            check("ready_valid_exclusive", {31'd0, in_ready & out_valid}, 32'd0);
            if (out_valid) begin
                if (!have_cur) begin
                    if (scb.size() == 0) begin
                        bad++;
                        total++;
                        $display("FAIL unexpected_output: got %h want no output", ALUResult);
                        cur = '{res: ALUResult, zero: Zero, ill: Illegal, acc: cyc, off: 0};
                    end else begin
                        cur = scb.pop_front();
                        check("latency_offset", cyc - cur.acc, cur.off);
                        check("result", ALUResult, cur.res);
                        check("zero", {31'd0, Zero}, {31'd0, cur.zero});
                        check("illegal", {31'd0, Illegal}, {31'd0, cur.ill});
                    end
                    have_cur  = 1'b1;
                    hold_res  = cur.res;
                    hold_zero = cur.zero;
                    hold_ill  = cur.ill;
                end else begin
                    check("stall_result_stable", ALUResult, cur.res);
                    check("stall_flags_stable", {30'd0, Zero, Illegal}, {30'd0, cur.zero, cur.ill});
                end
                if (stall_req > 0) begin
                    out_ready = 1'b0;
                    stall_req--;
                end else begin
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                if (out_ready) begin
                    have_cur    = 1'b0;
                    expect_idle = 1'b1;
                end
            end else begin
                check("idle_retain", {ALUResult}, hold_res);
                check("idle_retain_flags", {30'd0, Zero, Illegal}, {30'd0, hold_zero, hold_ill});
                out_ready = $urandom_range(0, 1);
            end
        end
    end

    // Directed vectors, including the boundary cases.
    logic [3:0]  d_op[10]   = '{4'h2, 4'h7, 4'h4, 4'hC, 4'h6, 4'hA, 4'h0, 4'h5, 4'h9, 4'h8};
    logic [31:0] d_a[10]    = '{32'd5, 32'h80000000, 32'h1234, 32'hFFFFFFFF, 32'd7,
                                32'h12345678, 32'hF0F0, 32'h80000000, 32'h80000000, 32'd5};
    logic [31:0] d_b[10]    = '{32'hFFFFFFFF, 32'd4, 32'h20, 32'd1, 32'd7,
                                32'h9ABCDEF0, 32'hFF00, 32'd31, 32'h7FFFFFFF, 32'd5};
    int          d_stall[10] = '{0, 0, 0, 0, 3, 0, 0, 0, 0, 0};

    task automatic random_batch(input int n);
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < n; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = $urandom_range(0, 40);
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) a = 32'h80000000;
            issue(4'($urandom), a, b, 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        Operation = '0;
        SrcA      = '0;
        SrcB      = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_result", ALUResult, 32'd0);
        check("reset_flags", {30'd0, Zero, Illegal}, 32'd2);

        for (int i = 0; i < 10; i++) issue(d_op[i], d_a[i], d_b[i], d_stall[i]);
        random_batch(250);
        drain();

        // Reset in the middle of a 20-cycle shift aborts it with no output.
        issue(4'h4, 32'h00000ABC, 32'd20, 0);
        scb.pop_back();
        check("shift_busy_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        check("shift_busy_valid", {31'd0, out_valid}, 32'd0);
        in_valid  = 1'b1;
        Operation = 4'h2;
        SrcA      = 32'd1;
        SrcB      = 32'd1;
        reset     = 1'b1;
        hold_res  = '0;
        hold_zero = 1'b1;
        hold_ill  = 1'b0;
        @(negedge clk);
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_result", ALUResult, 32'd0);
        check("abort_zero", {31'd0, Zero}, 32'd1);
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        check("abort_no_output", {31'd0, out_valid}, 32'd0);

        random_batch(80);
        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
